// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetches over req/ack, steps the decoder bank and gates its control word.
// Optional retire counter and `retired` port are built only when CTRL_SEQ_RETIRE_CNT_EN is defined.
module control_sequencer #(
    parameter bit RESET_PC_HOLD = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] imem_data,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] instruction,
    output logic [1:0]  state,
    output logic [3:0]  status,
    input  logic [28:0] dec_controlWord,
    input  logic [1:0]  dec_nextState,
    input  logic        dec_illegal,
    input  logic [3:0]  alu_status,
    input  logic        stall,
    output logic [28:0] controlWord,
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    output logic [31:0] retired,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fsm_t;

    // Psel[28:27], regW[6], ramW[5] and SL[0]: every field that changes architectural state
    localparam logic [28:0] WRITE_MASK = 29'h1800_0061;

    fsm_t        fsm;
    logic [31:0] ir;
    logic [1:0]  step;
    logic [3:0]  flags;
    logic        halt_q;

    logic in_exec;
    logic suppress;
    logic advance;
    logic retire;
    logic load_flags;

    assign in_exec    = (fsm == EXEC);
    assign suppress   = dec_illegal | stall;
    assign advance    = in_exec & ~suppress;
    assign retire     = advance & (dec_nextState == 2'd0);
    assign load_flags = advance & dec_controlWord[0];

    assign imem_req    = reset_n & (fsm == FETCH);
    assign instruction = ir;
    assign state       = step;
    assign status      = flags;
    assign halted      = halt_q;

    // The decoder word passes straight through only in a live execute cycle.
    always_comb begin
        controlWord = '0;
        if (in_exec) begin
            if (suppress) begin
                controlWord = dec_controlWord & ~WRITE_MASK;
            end else begin
                controlWord = dec_controlWord;
            end
        end
        if (RESET_PC_HOLD && !in_exec) begin
            controlWord[28:27] = 2'b00;
        end
    end

    // Illegal takes priority over stall, so a stalled illegal instruction still halts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm    <= FETCH;
            ir     <= '0;
            step   <= '0;
            flags  <= '0;
            halt_q <= 1'b0;
        end else begin
            case (fsm)
                FETCH: begin
                    if (imem_ack) begin
                        ir   <= imem_data;
                        step <= 2'd0;
                        fsm  <= EXEC;
                    end
                end
                EXEC: begin
                    if (dec_illegal) begin
                        fsm    <= HALT;
                        halt_q <= 1'b1;
                    end else if (advance) begin
                        if (load_flags) begin
                            flags <= alu_status;
                        end
                        if (retire) begin
                            step <= 2'd0;
                            fsm  <= FETCH;
                        end else begin
                            step <= dec_nextState;
                        end
                    end
                end
                HALT: begin
                    halt_q <= 1'b1;
                end
                default: begin
                    fsm <= FETCH;
                end
            endcase
        end
    end

`ifdef CTRL_SEQ_RETIRE_CNT_EN
    // Free-running wrap at 2^32; HALT never retires so it never counts there.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch handshake, single/multi-step, stall, illegal halt, mid-exec reset.
module tb_control_sequencer;

    logic        clock;
    logic        reset_n;
    logic [31:0] imem_data;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] instruction;
    logic [1:0]  state;
    logic [3:0]  status;
    logic [28:0] dec_controlWord;
    logic [1:0]  dec_nextState;
    logic        dec_illegal;
    logic [3:0]  alu_status;
    logic        stall;
    logic [28:0] controlWord;
    logic        halted;
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    int total = 0;
    int bad   = 0;

    control_sequencer dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .imem_data       (imem_data),
        .imem_ack        (imem_ack),
        .imem_req        (imem_req),
        .instruction     (instruction),
        .state           (state),
        .status          (status),
        .dec_controlWord (dec_controlWord),
        .dec_nextState   (dec_nextState),
        .dec_illegal     (dec_illegal),
        .alu_status      (alu_status),
        .stall           (stall),
        .controlWord     (controlWord),
`ifdef CTRL_SEQ_RETIRE_CNT_EN
        .retired         (retired),
`endif
        .halted          (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic applyStimulus(input logic ack, input logic [31:0] data, input logic [28:0] cw,
                                 input logic [1:0] nxt, input logic ill, input logic stl,
                                 input logic [3:0] alu);
        imem_ack        = ack;
        imem_data       = data;
        dec_controlWord = cw;
        dec_nextState   = nxt;
        dec_illegal     = ill;
        stall           = stl;
        alu_status      = alu;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkRetired(input string tag, input logic [31:0] expected);
`ifdef CTRL_SEQ_RETIRE_CNT_EN
        checkOutput(tag, retired, expected);
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 29'h1FFF_FFFF, 2'd0, 1'b0, 1'b0, 4'h0);
        #12;
        checkOutput("rst_cw", {3'b0, controlWord}, 32'h0);
        checkOutput("rst_state", {30'b0, state}, 32'h0);
        checkOutput("rst_status", {28'b0, status}, 32'h0);
        checkOutput("rst_ir", instruction, 32'h0);
        checkOutput("rst_halted", {31'b0, halted}, 32'h0);
        checkRetired("rst_retired", 32'h0);

        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkOutput("req_after_rst", {31'b0, imem_req}, 32'h1);

        // Three cycles with no ack: keep requesting, control word stays zero
        for (int i = 0; i < 3; i++) begin
            tick();
            applyStimulus(1'b0, 32'h0, 29'h1FFF_FFFF, 2'd0, 1'b0, 1'b0, 4'h0);
            checkOutput($sformatf("wait_req%0d", i), {31'b0, imem_req}, 32'h1);
            checkOutput($sformatf("wait_cw%0d", i), {3'b0, controlWord}, 32'h0);
        end
        applyStimulus(1'b1, 32'hB400_0041, 29'h1FFF_FFFF, 2'd0, 1'b0, 1'b0, 4'h0);
        tick();

        // Single-step instruction, SL set so status loads 1000
        applyStimulus(1'b0, 32'h0, 29'h0C00_000B, 2'd0, 1'b0, 1'b0, 4'b1000);
        checkOutput("ir1", instruction, 32'hB400_0041);
        checkOutput("ir1_state", {30'b0, state}, 32'h0);
        checkOutput("exec_req", {31'b0, imem_req}, 32'h0);
        checkOutput("single_cw", {3'b0, controlWord}, 32'h0C00_000B);
        tick();
        applyStimulus(1'b1, 32'h8B02_0020, 29'h1FFF_FFFF, 2'd0, 1'b0, 1'b0, 4'h0);
        checkOutput("single_back_fetch", {31'b0, imem_req}, 32'h1);
        checkOutput("single_cw_fetch", {3'b0, controlWord}, 32'h0);
        checkOutput("single_status", {28'b0, status}, 32'b1000);
        checkRetired("single_retired", 32'd1);
        tick();

        // Multi-step 0->1->2->0 with stall in step 1
        applyStimulus(1'b0, 32'h0, 29'h0000_0040, 2'd1, 1'b0, 1'b0, 4'b1111);
        checkOutput("ms_ir", instruction, 32'h8B02_0020);
        checkOutput("ms_s0_cw", {3'b0, controlWord}, 32'h0000_0040);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 29'h1FFF_FFFF, 2'd2, 1'b0, 1'b1, 4'b0010);
            checkOutput($sformatf("stall_cw%0d", i), {3'b0, controlWord}, 32'h07FF_FF9E);
            checkOutput($sformatf("stall_state%0d", i), {30'b0, state}, 32'h1);
            checkOutput($sformatf("stall_status%0d", i), {28'b0, status}, 32'b1000);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 29'h1FFF_FFFF, 2'd2, 1'b0, 1'b0, 4'b0010);
        checkOutput("resume_state", {30'b0, state}, 32'h1);
        checkOutput("resume_cw", {3'b0, controlWord}, 32'h1FFF_FFFF);
        tick();
        applyStimulus(1'b0, 32'h0, 29'h0000_0020, 2'd0, 1'b0, 1'b0, 4'b0101);
        checkOutput("ms_s2_state", {30'b0, state}, 32'h2);
        checkOutput("ms_status", {28'b0, status}, 32'b0010);
        checkOutput("ms_s2_req", {31'b0, imem_req}, 32'h0);
        tick();
        checkOutput("ms_done_req", {31'b0, imem_req}, 32'h1);
        checkOutput("ms_done_status", {28'b0, status}, 32'b0010);
        checkRetired("ms_retired", 32'd2);

        // Non-monotonic 0->3->1->0 while imem_ack stays high during EXEC
        applyStimulus(1'b1, 32'h1234_5678, 29'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b1, 32'hDEAD_BEEF, 29'h0000_0040, 2'd3, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b1, 32'hDEAD_BEEF, 29'h0000_0040, 2'd1, 1'b0, 1'b0, 4'h0);
        checkOutput("nm_state3", {30'b0, state}, 32'h3);
        checkOutput("nm_ir_hold", instruction, 32'h1234_5678);
        tick();
        applyStimulus(1'b0, 32'h0, 29'h0000_0040, 2'd0, 1'b0, 1'b0, 4'h0);
        checkOutput("nm_state1", {30'b0, state}, 32'h1);
        tick();
        checkOutput("nm_req", {31'b0, imem_req}, 32'h1);
        checkRetired("nm_retired", 32'd3);

        // Reset asserted during step 2
        applyStimulus(1'b1, 32'hFFFF_FFFF, 29'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 29'h0000_0040, 2'd2, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 29'h1FFF_FFFF, 2'd0, 1'b0, 1'b0, 4'b1111);
        checkOutput("mr_pre_state", {30'b0, state}, 32'h2);
        reset_n = 1'b0;
        #1;
        checkOutput("mr_cw", {3'b0, controlWord}, 32'h0);
        checkOutput("mr_state", {30'b0, state}, 32'h0);
        checkOutput("mr_status", {28'b0, status}, 32'h0);
        checkOutput("mr_ir", instruction, 32'h0);
        checkRetired("mr_retired", 32'h0);
        tick();
        checkOutput("mr_status_held", {28'b0, status}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Illegal together with stall: halt next cycle
        tick();
        applyStimulus(1'b1, 32'hCAFE_F00D, 29'h0, 2'd0, 1'b0, 1'b0, 4'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 29'h1FFF_FFFF, 2'd1, 1'b1, 1'b1, 4'b1111);
        checkOutput("ill_ir", instruction, 32'hCAFE_F00D);
        checkOutput("ill_cw", {3'b0, controlWord}, 32'h07FF_FF9E);
        checkOutput("ill_halted_pre", {31'b0, halted}, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h1111_1111, 29'h1FFF_FFFF, 2'd1, 1'b0, 1'b0, 4'b1111);
            checkOutput($sformatf("halt_flag%0d", i), {31'b0, halted}, 32'h1);
            checkOutput($sformatf("halt_req%0d", i), {31'b0, imem_req}, 32'h0);
            checkOutput($sformatf("halt_cw%0d", i), {3'b0, controlWord}, 32'h0);
            tick();
        end
        checkOutput("halt_status", {28'b0, status}, 32'h0);
        checkRetired("halt_retired", 32'h0);
        reset_n = 1'b0;
        #1;
        checkOutput("halt_cleared", {31'b0, halted}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Multi-cycle sequencer that sits between instruction memory, the per-instruction decoder bank (CBZ/CBNZ, B.cond, ALU, load/store, …) and the datapath. It fetches an instruction over a req/ack handshake and holds it in an instruction register. It then steps the decoder bank through its 2-bit `state` sequence, issuing the selected 29-bit control word to the datapath each cycle. It also owns the architectural status register {V,C,Z,N}, gates all write enables outside legal execute cycles, and halts on an illegal instruction.

## Interface
- `RESET_PC_HOLD`, default 1: when 1, Psel is forced to 2'b00 (hold PC) in every non-EXEC cycle.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_data`  in  32  instruction word from instruction memory.
- `imem_ack`  in  1  instruction memory has valid `imem_data` this cycle.
- `imem_req`  out  1  fetch request.
- `instruction`  out  32  instruction register contents, to the decoder bank.
- `state`  out  2  current execute step, to the decoder bank.
- `status`  out  4  registered {V,C,Z,N}, to the decoder bank.
- `dec_controlWord`  in  29  control word from the selected decoder.
- `dec_nextState`  in  2  next execute step from the selected decoder.
- `dec_illegal`  in  1  no decoder claims `instruction`.
- `alu_status`  in  4  {V,C,Z,N} from the ALU this cycle.
- `stall`  in  1  data-memory wait; freezes execute.
- `controlWord`  out  29  control word to the datapath.
- `halted`  out  1  sticky illegal-instruction halt.
- `retired`  out  32  retired-instruction count (CTRL_SEQ_RETIRE_CNT_EN only).

## Operation
- Control word layout, MSB to LSB: Psel[28:27], DA[26:22], SA[21:17], SB[16:12], Fsel[11:7], regW[6], ramW[5], Dsel[4:3], Bsel[2], PCsel[1], SL[0].
- FSM states: FETCH, EXEC, HALT.
- **FETCH**
  - `imem_req`=1.
  - On a clock edge with `imem_ack`=1: capture `imem_data` into IR, set `state`=0, go to EXEC.
  - Without `imem_ack`, remain in FETCH.
- **EXEC, `stall`=1**
  - `state`, IR and status are held.
  - `controlWord` = `dec_controlWord` with regW, ramW and SL forced to 0, and Psel forced to 00.
- **EXEC, `stall`=0**
  - `controlWord` = `dec_controlWord` unmodified.
  - At the clock edge:
    - If SL=1, status is loaded from `alu_status`.
    - If `dec_nextState`≠0, `state` is loaded with `dec_nextState` and the FSM stays in EXEC.
    - If `dec_nextState`=0, the instruction retires, `state` returns to 0 and the FSM goes to FETCH.
- **`dec_illegal`=1 in EXEC** (checked before stall):
  - `controlWord` has regW, ramW and SL forced to 0 and Psel forced to 00.
  - The FSM goes to HALT at the next edge.
- **HALT**
  - `halted`=1.
  - `imem_req`=0.
  - Write enables are 0.
  - Left only by reset.
- **Outside EXEC**
  - `controlWord` = 29'b0, with Psel=00 when `RESET_PC_HOLD`=1.
  - When `RESET_PC_HOLD`=0, Psel=00 is still required, since the whole word is 0.
- The block performs no arithmetic on the control word. K routes directly from the decoder to the datapath and does not pass through this block.

## Timing
- Reset values (asynchronous, all outputs):
  - FSM = FETCH, IR = 0, `state` = 0, status = 4'b0000.
  - `halted`=0, `retired`=0.
  - `controlWord`=0.
  - `imem_req`=1 once `reset_n` deasserts.
- Minimum instruction latency is 1 FETCH cycle (when `imem_ack` arrives in the first request cycle) plus N EXEC cycles, where N is the number of decoder steps (1–4).
- Status updates are visible on `status` in the cycle after the SL cycle. A conditional branch in a following instruction sees the new flags.
- `imem_ack` outside FETCH is ignored.
- `dec_illegal` and `stall` asserted together: illegal wins, and the FSM goes to HALT.
- A `dec_nextState` step sequence 0→3→1→0 is legal. The step order is not required to be monotonic.
- Reset asserted mid-EXEC: everything returns to reset values immediately, with no retire and no status update.

## Configuration
- `CTRL_SEQ_RETIRE_CNT_EN` defined:
  - `retired` is a 32-bit counter, incremented once per instruction retire (EXEC exit with `stall`=0 and `dec_nextState`=0).
  - It wraps from 0xFFFFFFFF to 0 and does not count in HALT.
- `CTRL_SEQ_RETIRE_CNT_EN` undefined: the `retired` port and the counter are absent.

## Test plan
- **Reset and fetch handshake:** release `reset_n`, hold `imem_ack`=0 for 3 cycles, then ack with 0xB4000041.
  - `imem_req`=1 throughout the wait.
  - IR=0xB4000041, `state`=0, EXEC on the next cycle.
  - `controlWord`=0 during the wait.
- **Single-step instruction:** decoder returns `dec_nextState`=0 with controlWord 0x0C00000B.
  - Exactly one EXEC cycle, outputting 0x0C00000B, then back to FETCH.
  - `retired` increments by 1 (macro on).
- **Multi-step with status:** steps 0→1→2→0, SL=1 in step 1 only, `alu_status`=4'b0010.
  - `status`=0010 from the cycle after step 1.
  - 3 EXEC cycles total.
- **Stall:** `stall`=1 for 2 cycles during step 1, with `dec_controlWord` regW=ramW=SL=1.
  - `controlWord` bits 6, 5 and 0 are 0 and Psel=00.
  - `state` is held at 1; status is unchanged.
  - Step 1 resumes with its full control word afterwards.
- **Illegal instruction:** `dec_illegal`=1 in EXEC together with `stall`=1.
  - HALT next cycle, `halted`=1, `imem_req`=0.
  - `controlWord` write enables stay 0.
  - `halted` clears only on `reset_n`=0.
- **Reset mid-EXEC:** assert `reset_n`=0 during step 2.
  - All outputs are at reset values within the same cycle.
  - `retired` and `status` are 0.
